// File: rtl/control_multiciclo_if.sv
// Control/datapath bundle for the multicycle MIPS controller: opcode and
// memory handshake in, datapath enables, mux selects and debug state out.
interface control_multiciclo_if;
    logic [5:0] opcode;
    logic       mem_listo;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       opcode_invalido;
    logic [3:0] estado;

    modport master (
        input  opcode, mem_listo,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, opcode_invalido, estado
    );

    modport slave (
        output opcode, mem_listo,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, opcode_invalido, estado
    );
endinterface

// File: rtl/control_multiciclo.sv
// Moore control FSM for the multicycle MIPS datapath: fetch/decode/execute/
// memory/writeback sequencing with memory-ready stalls and bad-opcode flag.
module control_multiciclo #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic                 clk,
    input  logic                 reset_n,
    control_multiciclo_if.master bus
);

    localparam logic [3:0] INICIO = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] MEMADR = 4'd3;
    localparam logic [3:0] MEMRD  = 4'd4;
    localparam logic [3:0] MEMWB  = 4'd5;
    localparam logic [3:0] MEMWR  = 4'd6;
    localparam logic [3:0] EXEC   = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] JUMP   = 4'd10;
    localparam logic [3:0] ADDIEX = 4'd11;
    localparam logic [3:0] ADDIWB = 4'd12;

    logic [3:0] state;
    logic [3:0] nextState;

    // NOTE: state is updated with <= so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= INICIO;
        else          state <= nextState;
    end

    // NOTE: nextState gets a default before the case so no path infers a latch.
    always_comb begin
        nextState = FETCH;
        case (state)
            INICIO: nextState = FETCH;
            FETCH:  nextState = bus.mem_listo ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = ADDIEX;
                    default:      nextState = FETCH;
                endcase
            end
            // Only LW and SW can reach MEMADR, so a non-SW opcode means load.
            MEMADR: nextState = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nextState = bus.mem_listo ? MEMWB : MEMRD;
            MEMWB:  nextState = FETCH;
            MEMWR:  nextState = bus.mem_listo ? FETCH : MEMWR;
            EXEC:   nextState = ALUWB;
            ALUWB:  nextState = FETCH;
            BRANCH: nextState = FETCH;
            JUMP:   nextState = FETCH;
            ADDIEX: nextState = ADDIWB;
            ADDIWB: nextState = FETCH;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        bus.PCWrite         = 1'b0;
        bus.PCWriteCond     = 1'b0;
        bus.IorD            = 1'b0;
        bus.MemRead         = 1'b0;
        bus.MemWrite        = 1'b0;
        bus.IRWrite         = 1'b0;
        bus.MemtoReg        = 1'b0;
        bus.RegDst          = 1'b0;
        bus.RegWrite        = 1'b0;
        bus.ALUSrcA         = 1'b0;
        bus.ALUSrcB         = 2'd0;
        bus.ALUOp           = 2'd0;
        bus.PCSource        = 2'd0;
        bus.opcode_invalido = 1'b0;
        case (state)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'd1;
                // IR and PC+4 are committed only once the memory word is valid.
                bus.IRWrite = bus.mem_listo;
                bus.PCWrite = bus.mem_listo;
            end
            DECODE: begin
                bus.ALUSrcB = 2'd3;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: ;
                    default: bus.opcode_invalido = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'd2;
            end
            ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'd1;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'd1;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'd2;
            end
            ADDIWB: bus.RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign bus.estado = state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo: instruction-level trace model,
// latency table, random instruction stream and reset corner cases.
module tb_control_multiciclo;

    logic clk = 1'b0;
    logic reset_n;
    control_multiciclo_if bus();

    control_multiciclo dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
        logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, PCSource;
        logic       opcode_invalido;
        logic [3:0] estado;
    } out_t;

    typedef struct {
        logic [3:0] st;
        logic       listo;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        int         fetchStall;
        int         memStall;
        int         baseLat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic isLegal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    function automatic int latencyOf(input logic [5:0] op);
        case (op)
            6'h23:               return 5;
            6'h2B, 6'h00, 6'h08: return 4;
            6'h04, 6'h02:        return 3;
            default:             return 2;
        endcase
    endfunction

    // Expected outputs per step of an instruction, straight from the step table.
    function automatic out_t model(input logic [3:0] st, input logic listo, input logic [5:0] op);
        out_t o = '0;
        o.estado = st;
        case (st)
            4'd1:  begin o.MemRead = 1; o.ALUSrcB = 2'd1; o.IRWrite = listo; o.PCWrite = listo; end
            4'd2:  begin o.ALUSrcB = 2'd3; o.opcode_invalido = !isLegal(op); end
            4'd3:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'd2; end
            4'd4:  begin o.MemRead = 1; o.IorD = 1; end
            4'd5:  begin o.MemtoReg = 1; o.RegWrite = 1; end
            4'd6:  begin o.MemWrite = 1; o.IorD = 1; end
            4'd7:  begin o.ALUSrcA = 1; o.ALUOp = 2'd2; end
            4'd8:  begin o.RegDst = 1; o.RegWrite = 1; end
            4'd9:  begin o.ALUSrcA = 1; o.ALUOp = 2'd1; o.PCWriteCond = 1; o.PCSource = 2'd1; end
            4'd10: begin o.PCWrite = 1; o.PCSource = 2'd2; end
            4'd11: begin o.ALUSrcA = 1; o.ALUSrcB = 2'd2; end
            4'd12: o.RegWrite = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.PCWrite = bus.PCWrite;   o.PCWriteCond = bus.PCWriteCond;
        o.IorD = bus.IorD;         o.MemRead = bus.MemRead;
        o.MemWrite = bus.MemWrite; o.IRWrite = bus.IRWrite;
        o.MemtoReg = bus.MemtoReg; o.RegDst = bus.RegDst;
        o.RegWrite = bus.RegWrite; o.ALUSrcA = bus.ALUSrcA;
        o.ALUSrcB = bus.ALUSrcB;   o.ALUOp = bus.ALUOp;
        o.PCSource = bus.PCSource; o.opcode_invalido = bus.opcode_invalido;
        o.estado = bus.estado;
        return o;
    endfunction

    task automatic checkNow(input string tag, input logic [3:0] st, input logic listo, input logic [5:0] op);
        out_t act;
        act = sample();
        check($sformatf("%s st%0d", tag, st), 32'(act), 32'(model(st, listo, op)));
        check($sformatf("%s invariants", tag),
              {28'd0, act.MemRead & act.MemWrite, act.RegWrite & act.MemWrite,
               act.PCSource == 2'd3, act.ALUOp == 2'd3}, 32'd0);
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic listo, input logic [3:0] st);
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_listo = listo;
        #1;
        checkNow(tag, st, listo, op);
    endtask

    // Entry: DUT will be in FETCH for the next clock cycle.
    task automatic runInstr(input string tag, input logic [5:0] op, input int fs, input int ms, input int baseLat);
        cyc_t q[$];
        int   expLat;
        logic [5:0] drv;
        for (int i = 0; i < fs; i++) q.push_back('{4'd1, 1'b0});
        q.push_back('{4'd1, 1'b1});
        q.push_back('{4'd2, 1'($urandom_range(1))});
        case (op)
            6'h23: begin
                q.push_back('{4'd3, 1'($urandom_range(1))});
                for (int i = 0; i < ms; i++) q.push_back('{4'd4, 1'b0});
                q.push_back('{4'd4, 1'b1});
                q.push_back('{4'd5, 1'($urandom_range(1))});
            end
            6'h2B: begin
                q.push_back('{4'd3, 1'($urandom_range(1))});
                for (int i = 0; i < ms; i++) q.push_back('{4'd6, 1'b0});
                q.push_back('{4'd6, 1'b1});
            end
            6'h00: begin q.push_back('{4'd7, 1'($urandom_range(1))}); q.push_back('{4'd8, 1'($urandom_range(1))}); end
            6'h04: q.push_back('{4'd9, 1'($urandom_range(1))});
            6'h02: q.push_back('{4'd10, 1'($urandom_range(1))});
            6'h08: begin q.push_back('{4'd11, 1'($urandom_range(1))}); q.push_back('{4'd12, 1'($urandom_range(1))}); end
            default: ;
        endcase
        foreach (q[i]) begin
            // Opcode is only meaningful in DECODE/MEMADR; scramble it elsewhere.
            drv = (q[i].st == 4'd2 || q[i].st == 4'd3) ? op : 6'($urandom_range(63));
            step(tag, drv, q[i].listo, q[i].st);
        end
        expLat = baseLat + fs + ((op == 6'h23 || op == 6'h2B) ? ms : 0);
        @(posedge clk);
        #1;
        check($sformatf("%s latency", tag), (bus.estado == 4'd1) ? q.size() : 0, expLat);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{6'h23, 0, 0, 5};
        vecs[1] = '{6'h2B, 0, 2, 4};
        vecs[2] = '{6'h00, 4, 0, 4};
        vecs[3] = '{6'h04, 0, 0, 3};
        vecs[4] = '{6'h02, 0, 0, 3};
        vecs[5] = '{6'h3F, 0, 0, 2};
        vecs[6] = '{6'h08, 1, 0, 4};
        vecs[7] = '{6'h23, 2, 3, 5};

        reset_n       = 1'b0;
        bus.opcode    = 6'h00;
        bus.mem_listo = 1'b1;

        // Reset held three cycles, then released into INICIO -> FETCH.
        for (int i = 0; i < 3; i++) step("reset", 6'h00, 1'b1, 4'd0);
        reset_n = 1'b1;
        #1;
        checkNow("release", 4'd0, 1'b1, 6'h00);
        runInstr("first_rtype", 6'h00, 0, 0, 4);

        foreach (vecs[i])
            runInstr($sformatf("vec%0d", i), vecs[i].op, vecs[i].fetchStall,
                     vecs[i].memStall, vecs[i].baseLat);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            case ($urandom_range(6))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                default: op = 6'($urandom_range(63));
            endcase
            runInstr($sformatf("rand%0d", n), op, $urandom_range(2), $urandom_range(2), latencyOf(op));
        end

        // Asynchronous reset while stalled in MEMRD.
        step("midrst", 6'h23, 1'b1, 4'd1);
        step("midrst", 6'h23, 1'b1, 4'd2);
        step("midrst", 6'h23, 1'b1, 4'd3);
        step("midrst", 6'h23, 1'b0, 4'd4);
        step("midrst", 6'h23, 1'b0, 4'd4);
        reset_n = 1'b0;
        #1;
        checkNow("midrst_async", 4'd0, 1'b0, 6'h23);
        step("midrst_hold", 6'h23, 1'b1, 4'd0);
        reset_n = 1'b1;
        #1;
        checkNow("midrst_release", 4'd0, 1'b1, 6'h23);
        step("midrst_fetch", 6'h2B, 1'b0, 4'd1);
        runInstr("after_rst", 6'h04, 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Moore FSM control unit for the multicycle MIPS datapath. It sequences the fetch, decode, execute, memory and writeback steps for each instruction. It drives every datapath enable and the 2-bit selects of the 4-input 32-bit operand and PC-source muxes (ALUSrcB, PCSource). It stalls on a memory-ready handshake and flags unsupported opcodes.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_J, 6'h02, jump opcode
OP_ADDI, 6'h08, add-immediate opcode

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], held stable by IR outside FETCH
mem_listo  in  1  memory has completed the current read or write this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath enables and 1-bit selects
ALUSrcB  out  2  0 = reg B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
ALUOp  out  2  0 = add, 1 = sub, 2 = decode funct, 3 = never driven
PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = never driven
opcode_invalido  out  1  high during DECODE when opcode is unsupported
estado  out  4  current state code, for debug

Behaviour:
- State register is the only storage. All outputs are combinational from state; the only exception is the FETCH gating on mem_listo. Any output not listed for a state is 0.
- State codes: INICIO=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12. Codes 13-15 are illegal and go to FETCH on the next edge with all outputs 0.
- reset_n low: state goes to INICIO immediately, asynchronously. This applies even mid-instruction and mid-stall. All outputs are 0 and estado=0. After reset is released, INICIO goes to FETCH on the first edge.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0, IRWrite=PCWrite=mem_listo.
  - Stays in FETCH while mem_listo=0. Goes to DECODE on the edge where mem_listo=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDIEX
  - any other opcode -> FETCH, with opcode_invalido=1 for this single cycle
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Holds while mem_listo=0, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds while mem_listo=0, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=2. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH.
- Latency in cycles, counted FETCH to next FETCH, with mem_listo=1: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, invalid 2. Each mem_listo=0 cycle in FETCH, MEMRD or MEMWR adds 1.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - RegWrite is never 1 in the same cycle as MemWrite.
  - PCSource=3 and ALUOp=3 are never produced.
- opcode is sampled only in DECODE and MEMADR. Changes in any other state have no effect.

Test Plan:
- Reset held for 3 cycles, then released with mem_listo=1 and opcode=6'h00 -> all outputs 0 during reset; estado sequence is 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8.
- opcode=6'h23, mem_listo=1 -> estado 1,2,3,4,5,1; ALUSrcB=1,3,2 in states 1,2,3; MemtoReg=1 and RegWrite=1 in state 5.
- opcode=6'h2B, mem_listo low for 2 cycles in MEMWR -> MemWrite=1 for 3 cycles with IorD=1, then FETCH; RegWrite stays 0 throughout.
- FETCH with mem_listo=0 for 4 cycles -> IRWrite=PCWrite=0 for 4 cycles, MemRead=1; fifth cycle with mem_listo=1 gives IRWrite=PCWrite=1, then DECODE.
- opcode=6'h04, then 6'h02 -> BEQ: PCWriteCond=1, PCSource=1, ALUOp=1 in state 9. J: PCWrite=1, PCSource=2 in state 10. Each takes 3 cycles.
- opcode=6'h3F -> opcode_invalido=1 for exactly one cycle in state 2, then FETCH. reset_n pulsed low mid-MEMRD -> estado=0 immediately, all outputs 0.
